// File: rtl/zx_video_pkg.sv
// Shared constants, types and IO decode for the ZX80/ZX81 video engine.
package zx_video_pkg;

   localparam int unsigned LINE_CLKS_DEF = 207;
   localparam int unsigned HS_START_DEF  = 16;
   localparam int unsigned HS_END_DEF    = 31;
   localparam int unsigned BP_PIX_DEF    = 31;
   localparam int unsigned ROW_W         = 3;
   localparam int unsigned CHAR_IDX_W    = 6;

   typedef logic [ROW_W-1:0] row_t;

   typedef struct packed {
      logic io_wr;    // any OUT
      logic kbd_rd;   // IN from an even port (keyboard)
      logic nmi_sel;  // OUT FE / OUT FD
   } io_dec_t;

   function automatic io_dec_t zx_io_decode(input logic iorq_n, input logic rd_n,
                                            input logic wr_n, input logic [1:0] a);
      io_dec_t d;
      d.io_wr   = !iorq_n && !wr_n;
      d.kbd_rd  = !iorq_n && !rd_n && !a[0];
      d.nmi_sel = d.io_wr && (a[0] ^ a[1]);
      return d;
   endfunction

endpackage

// File: rtl/zx_video_engine_if.sv
// Z80 bus view shared between the CPU side (master) and the video engine (slave).
interface zx_video_engine_if;
   logic [15:0] addr;
   logic        m1_n;
   logic        mreq_n;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        rfsh_n;
   logic        halt_n;
   logic [7:0]  mem_data;
   logic        nop_force;
   logic        nmi_n;
   logic        wait_n;

   modport master (
      output addr, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, mem_data,
      input  nop_force, nmi_n, wait_n
   );

   modport slave (
      input  addr, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, mem_data,
      output nop_force, nmi_n, wait_n
   );
endinterface

// File: rtl/zx_sync_gen.sv
// Line counter, horizontal/vertical sync, NMI latch and NMI/WAIT generation.
module zx_sync_gen
   import zx_video_pkg::*;
#(
   parameter int unsigned LINE_CLKS = LINE_CLKS_DEF,
   parameter int unsigned HS_START  = HS_START_DEF,
   parameter int unsigned HS_END    = HS_END_DEF,
   parameter int unsigned CNT_W     = $clog2(LINE_CLKS)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce_cpu_n,
   input  logic       zx81,
   input  logic [1:0] addr_lo,
   input  logic       m1_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       halt_n,
   output logic       csync,
   output logic       vsync_n,
   output logic       nmi_n,
   output logic       wait_n,
   output logic       nmi_on
);

   logic [CNT_W-1:0] count;
   logic             hsync_n;
   io_dec_t          io;

   assign io = zx_io_decode(iorq_n, rd_n, wr_n, addr_lo);

   // Interrupt acknowledge realigns the line to the CPU, taking priority over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (ce_cpu_n) begin
         if (count == CNT_W'(LINE_CLKS - 1) || (!m1_n && !iorq_n))
            count <= '0;
         else
            count <= count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         nmi_on <= 1'b0;
      else if (zx81 && io.nmi_sel)
         nmi_on <= addr_lo[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_n <= 1'b1;
      end else if (!zx81 || !nmi_on) begin
         if (io.kbd_rd)
            vsync_n <= 1'b0;
         else if (io.io_wr)
            vsync_n <= 1'b1;
      end
   end

   assign hsync_n = !((count >= CNT_W'(HS_START)) && (count <= CNT_W'(HS_END)));
   assign csync   = hsync_n & vsync_n;
   assign nmi_n   = !(zx81 && nmi_on && !hsync_n);
   assign wait_n  = !(halt_n && !nmi_n);

endmodule

// File: rtl/zx_video_engine.sv
// ZX80/ZX81 display engine: NOP forcing, char ROM addressing, row counter, pixel shifter.
// Optional ZXVID_CHR128_EN adds the chr128 port for 128-glyph character sets.
module zx_video_engine
   import zx_video_pkg::*;
#(
   parameter int unsigned LINE_CLKS = LINE_CLKS_DEF,
   parameter int unsigned HS_START  = HS_START_DEF,
   parameter int unsigned HS_END    = HS_END_DEF,
   parameter int unsigned BP_PIX    = BP_PIX_DEF,
   parameter int unsigned INVERT    = 0,
   parameter int unsigned CNT_W     = $clog2(LINE_CLKS)
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 ce_cpu_p,
   input  logic                 ce_cpu_n,
   input  logic                 ce_pix,
   input  logic                 zx81,
   zx_video_engine_if.slave     bus,
   output logic [12:0]          char_a,
   output logic                 csync,
   output logic                 vsync_n,
   output logic                 video
`ifdef ZXVID_CHR128_EN
   ,
   input  logic                 chr128
`endif
);

   localparam int unsigned BP_W = $clog2(BP_PIX + 1);

   logic            nmi_on;
   logic            nop_term;
   logic [7:0]      chr;
   logic            nop_store;
   row_t            row;
   logic            csync_d;
   logic            start;
   logic            start_d;
   logic [7:0]      shift;
   logic            inverse;
   logic [BP_W-1:0] bp;
   logic            glyph128;
   logic            unused_bits;

`ifdef ZXVID_CHR128_EN
   assign glyph128 = chr128;
`else
   assign glyph128 = 1'b0;
`endif

   assign unused_bits = ^{bus.addr[14:13], chr[6]};

   zx_sync_gen #(
      .LINE_CLKS (LINE_CLKS),
      .HS_START  (HS_START),
      .HS_END    (HS_END),
      .CNT_W     (CNT_W)
   ) u_sync (
      .clk      (clk_sys),
      .rst      (reset),
      .ce_cpu_n (ce_cpu_n),
      .zx81     (zx81),
      .addr_lo  (bus.addr[1:0]),
      .m1_n     (bus.m1_n),
      .iorq_n   (bus.iorq_n),
      .rd_n     (bus.rd_n),
      .wr_n     (bus.wr_n),
      .halt_n   (bus.halt_n),
      .csync    (csync),
      .vsync_n  (vsync_n),
      .nmi_n    (bus.nmi_n),
      .wait_n   (bus.wait_n),
      .nmi_on   (nmi_on)
   );

   assign nop_term      = bus.addr[15] & ~bus.mem_data[6] & bus.halt_n;
   assign bus.nop_force = nop_term & ~bus.m1_n & ~bus.mreq_n;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         chr       <= '0;
         nop_store <= 1'b0;
      end else if (bus.rfsh_n && !bus.mreq_n && ce_cpu_n) begin
         chr       <= bus.mem_data;
         nop_store <= nop_term;
      end
   end

   always_comb begin
      char_a = bus.addr[12:0];
      if (!bus.rfsh_n)
         char_a = {bus.addr[12:10], (glyph128 ? chr[7] : bus.addr[9]),
                   chr[CHAR_IDX_W-1:0], row};
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         csync_d <= 1'b1;
         row     <= '0;
      end else begin
         csync_d <= csync;
         if (!vsync_n)
            row <= '0;
         else if (csync_d && !csync)
            row <= row + row_t'(1);
      end
   end

   assign start = bus.mreq_n & nop_store & ce_cpu_p & (~zx81 | ~nmi_on);

   // A load takes precedence over both the pixel shift and the inverse clear.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         start_d <= 1'b0;
         shift   <= '0;
         inverse <= 1'b0;
      end else begin
         start_d <= start;
         if (start && !start_d) begin
            shift   <= bus.mem_data;
            inverse <= chr[7] & ~glyph128;
         end else begin
            if (ce_pix)
               shift <= {shift[6:0], 1'b0};
            if (bus.mreq_n && ce_cpu_p)
               inverse <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         bp <= BP_W'(1);
      else if (!csync_d && csync)
         bp <= BP_W'(1);
      else if (ce_pix && bp != '0)
         bp <= (bp == BP_W'(BP_PIX)) ? '0 : bp + BP_W'(1);
   end

   assign video = ((INVERT == 0) ^ shift[7] ^ inverse) & (bp == '0) & csync;

endmodule

// File: tb/tb_zx_video_engine.sv
// Directed self-checking bench for zx_video_engine (default parameters).
module tb_zx_video_engine;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_cpu_p, ce_cpu_n, ce_pix, zx81;
   logic [12:0] char_a;
   logic        csync, vsync_n, video;
`ifdef ZXVID_CHR128_EN
   logic        chr128;
`endif

   int vectors = 0;
   int miscompares = 0;

   zx_video_engine_if bus ();

   zx_video_engine dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ce_cpu_p (ce_cpu_p),
      .ce_cpu_n (ce_cpu_n),
      .ce_pix   (ce_pix),
      .zx81     (zx81),
      .bus      (bus),
      .char_a   (char_a),
      .csync    (csync),
      .vsync_n  (vsync_n),
      .video    (video)
`ifdef ZXVID_CHR128_EN
      ,
      .chr128   (chr128)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed no finish, required finish within budget");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse_cpun(input int n);
      for (int i = 0; i < n; i++) begin
         ce_cpu_n = 1'b1; tick();
         ce_cpu_n = 1'b0; tick();
      end
   endtask

   task automatic pulse_cpup();
      ce_cpu_p = 1'b1; tick();
      ce_cpu_p = 1'b0; tick();
   endtask

   task automatic pulse_pix(input int n);
      for (int i = 0; i < n; i++) begin
         ce_pix = 1'b1; tick();
         ce_pix = 1'b0; tick();
      end
   endtask

   task automatic io_write(input logic [15:0] a);
      bus.addr = a; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; tick();
      bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.addr = '0;
   endtask

   task automatic io_read(input logic [15:0] a);
      bus.addr = a; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; tick();
      bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.addr = '0;
   endtask

   task automatic intack();
      bus.m1_n = 1'b0; bus.iorq_n = 1'b0; ce_cpu_n = 1'b1; tick();
      bus.m1_n = 1'b1; bus.iorq_n = 1'b1; ce_cpu_n = 1'b0; tick();
   endtask

   // M1 fetch from the display file: latches the character and its NOP flag.
   task automatic fetch(input logic [15:0] a, input logic [7:0] d);
      bus.addr = a; bus.mem_data = d; bus.m1_n = 1'b0; bus.mreq_n = 1'b0;
      pulse_cpun(1);
      bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.addr = '0;
   endtask

   task automatic load_glyph(input logic [7:0] d);
      bus.mem_data = d; bus.mreq_n = 1'b1;
      pulse_cpup();
   endtask

   task automatic expect_pixels(input string tag, input logic [7:0] seq);
      for (int i = 0; i < 8; i++) begin
         check(tag, 16'(video), 16'(seq[7-i]));
         pulse_pix(1);
      end
   endtask

   initial begin
      reset = 1'b1; ce_cpu_p = 1'b0; ce_cpu_n = 1'b0; ce_pix = 1'b0; zx81 = 1'b0;
`ifdef ZXVID_CHR128_EN
      chr128 = 1'b0;
`endif
      bus.addr = '0; bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
      bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.rfsh_n = 1'b1; bus.halt_n = 1'b1;
      bus.mem_data = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_csync", 16'(csync), 16'h1);
      check("rst_vsync", 16'(vsync_n), 16'h1);
      check("rst_nmi", 16'(bus.nmi_n), 16'h1);
      check("rst_wait", 16'(bus.wait_n), 16'h1);
      check("rst_video", 16'(video), 16'h0);
      check("rst_nop", 16'(bus.nop_force), 16'h0);
      check("rst_char_a", 16'(char_a), 16'h0000);

      // Free-running lines: sync low for counts 16..31 of every 207
      for (int ln = 0; ln < 3; ln++) begin
         int first, last, lows;
         first = -1; last = -1; lows = 0;
         for (int i = 0; i < 207; i++) begin
            if (csync == 1'b0) begin
               if (first < 0) first = i;
               last = i;
               lows++;
            end
            pulse_cpun(1);
         end
         check("hs_first", 16'(first), 16'd16);
         check("hs_last", 16'(last), 16'd31);
         check("hs_width", 16'(lows), 16'd16);
      end

      // Interrupt acknowledge clears the counter
      pulse_cpun(20);
      check("ia_pre", 16'(csync), 16'h0);
      intack();
      check("ia_clr", 16'(csync), 16'h1);
      pulse_cpun(15);
      check("ia_15", 16'(csync), 16'h1);
      pulse_cpun(1);
      check("ia_16", 16'(csync), 16'h0);
      pulse_cpun(191);

      // ZX81 NMI generator
      zx81 = 1'b1;
      io_write(16'h00FE);
      check("nmi_idle", 16'(bus.nmi_n), 16'h1);
      check("wait_idle", 16'(bus.wait_n), 16'h1);
      pulse_cpun(16);
      check("nmi_hs16", 16'(bus.nmi_n), 16'h0);
      check("wait_hs16", 16'(bus.wait_n), 16'h0);
      bus.halt_n = 1'b0; #1;
      check("wait_nohalt", 16'(bus.wait_n), 16'h1);
      bus.halt_n = 1'b1;
      pulse_cpun(15);
      check("nmi_hs31", 16'(bus.nmi_n), 16'h0);
      pulse_cpun(1);
      check("nmi_hs32", 16'(bus.nmi_n), 16'h1);
      io_read(16'h7FFE);
      check("vs_gated", 16'(vsync_n), 16'h1);
      pulse_cpun(191);
      check("nmi_line2", 16'(bus.nmi_n), 16'h0);
      io_write(16'h00FD);
      check("nmi_off", 16'(bus.nmi_n), 16'h1);
      pulse_cpun(191);
      pulse_cpun(16);
      check("nmi_off_hs", 16'(bus.nmi_n), 16'h1);
      pulse_cpun(191);
      zx81 = 1'b0;

      // Vertical sync and row counter (ZX80)
      bus.rfsh_n = 1'b0;
      io_read(16'h7FFE);
      tick();
      check("vs_on", 16'(vsync_n), 16'h0);
      check("vs_csync", 16'(csync), 16'h0);
      check("row_held0", 16'(char_a), 16'h0000);
      pulse_cpun(207);
      check("row_held1", 16'(char_a), 16'h0000);
      io_write(16'h00FF);
      check("vs_off", 16'(vsync_n), 16'h1);
      for (int k = 1; k <= 8; k++) begin
         pulse_cpun(207);
         check("row_cnt", 16'(char_a), 16'(k % 8));
      end
      pulse_cpun(3 * 207);
      check("row_3", 16'(char_a), 16'h0003);
      io_read(16'h7FFE);
      tick();
      check("row_clr", 16'(char_a), 16'h0000);
      io_write(16'h00FF);
      pulse_cpun(2 * 207);
      check("row_2", 16'(char_a), 16'h0002);
      bus.rfsh_n = 1'b1;

      // NOP forcing and char ROM addressing
      bus.addr = 16'hC000; bus.mem_data = 8'h05; bus.m1_n = 1'b0; bus.mreq_n = 1'b0; #1;
      check("nop_on", 16'(bus.nop_force), 16'h1);
      bus.mem_data = 8'h45; #1;
      check("nop_bit6", 16'(bus.nop_force), 16'h0);
      bus.mem_data = 8'h05; bus.halt_n = 1'b0; #1;
      check("nop_halt", 16'(bus.nop_force), 16'h0);
      bus.halt_n = 1'b1; bus.addr = 16'h4000; #1;
      check("nop_a15", 16'(bus.nop_force), 16'h0);
      bus.addr = 16'hC000; bus.m1_n = 1'b1; #1;
      check("nop_m1", 16'(bus.nop_force), 16'h0);
      bus.m1_n = 1'b1; bus.mreq_n = 1'b1;
      fetch(16'hC000, 8'h05);
      bus.addr = 16'h1E00; bus.rfsh_n = 1'b0; bus.mreq_n = 1'b0; #1;
      check("char_a_rfsh", 16'(char_a), 16'h1E2A);
      bus.rfsh_n = 1'b1; #1;
      check("char_a_pass", 16'(char_a), 16'h1E00);
      bus.mreq_n = 1'b1; bus.addr = '0;

      // Back porch after the last csync rise
      check("bp_start", 16'(video), 16'h0);
      pulse_pix(30);
      check("bp_30", 16'(video), 16'h0);
      pulse_pix(1);
      check("bp_31", 16'(video), 16'h1);

      // Glyph shifting, normal then inverse character
      load_glyph(8'hF0);
      expect_pixels("pix_norm", 8'b0000_1111);
      check("pix_norm_end", 16'(video), 16'h1);
      fetch(16'hC000, 8'h85);
      load_glyph(8'hF0);
      expect_pixels("pix_inv", 8'b1111_0000);
      check("pix_inv_end", 16'(video), 16'h0);
      fetch(16'h4000, 8'h85);
      check("inv_hold", 16'(video), 16'h0);
      load_glyph(8'h7F);
      check("inv_clr", 16'(video), 16'h1);

`ifdef ZXVID_CHR128_EN
      chr128 = 1'b1;
      fetch(16'hC000, 8'h85);
      bus.rfsh_n = 1'b0; #1;
      check("c128_char_a", 16'(char_a), 16'h022A);
      bus.rfsh_n = 1'b1;
      load_glyph(8'hF0);
      expect_pixels("c128_pix", 8'b0000_1111);
      chr128 = 1'b0;
`endif

      // Asynchronous reset in the middle of a glyph with NMI and vsync active
      fetch(16'hC000, 8'h05);
      load_glyph(8'hFF);
      check("pre_rst_pix", 16'(video), 16'h0);
      zx81 = 1'b1;
      io_write(16'h00FE);
      intack();
      pulse_cpun(16);
      check("pre_rst_nmi", 16'(bus.nmi_n), 16'h0);
      zx81 = 1'b0;
      io_read(16'h7FFE);
      zx81 = 1'b1; #1;
      check("pre_rst_vs", 16'(vsync_n), 16'h0);
      check("pre_rst_wait", 16'(bus.wait_n), 16'h0);
      reset = 1'b1;
      #2;
      check("arst_video", 16'(video), 16'h0);
      check("arst_vsync", 16'(vsync_n), 16'h1);
      check("arst_nmi", 16'(bus.nmi_n), 16'h1);
      check("arst_wait", 16'(bus.wait_n), 16'h1);
      check("arst_csync", 16'(csync), 16'h1);
      bus.rfsh_n = 1'b0; #1;
      check("arst_char_a", 16'(char_a), 16'h0000);
      bus.rfsh_n = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      pulse_pix(30);
      check("post_bp30", 16'(video), 16'h0);
      pulse_pix(1);
      check("post_bp31", 16'(video), 16'h1);
      pulse_cpun(16);
      check("post_hs", 16'(video), 16'h0);
      pulse_cpun(16);
      check("post_rise", 16'(video), 16'h0);
      pulse_pix(30);
      check("post_rise30", 16'(video), 16'h0);
      pulse_pix(1);
      check("post_rise31", 16'(video), 16'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
